eflags_wb: RTL and testbench

- Architectural EFLAGS register and flag scoreboard for the pipelined x86 core, on the consumer side of the execute-stage ALU flag outputs.
- Commits the 6-bit ALU/CMPS flag vectors and their per-flag load enables at writeback. Also commits DF updates and POPF/IRET-style images.
- Tracks in-flight flag writers per flag, so an issuing flag reader (Jcc, DAA, ADC-class, CMPS/REP) stalls until its flags are architectural.
- Drives CF/AF/DF back to execute.

---
 rtl/eflags_wb.sv | 79 +++++++
 tb/tb_eflags_wb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/eflags_wb.sv
// eflags_wb: architectural EFLAGS register with a per-flag in-flight writer scoreboard
module eflags_wb #(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [5:0]  wb_ld_flags,
  input  logic [5:0]  wb_flags,
  input  logic        wb_cmps_sel,
  input  logic [5:0]  wb_cmps_flags,
  input  logic        wb_ld_df,
  input  logic        wb_df_val,
  input  logic        wb_popf,
  input  logic [31:0] wb_popf_data,
  input  logic        iss_valid,
  input  logic [5:0]  iss_ld_flags,
  input  logic        iss_ld_df,
  input  logic [5:0]  iss_rd_flags,
  input  logic        iss_rd_df,
  input  logic        flush,
  output logic [31:0] eflags,
  output logic        CF_out,
  output logic        AF_out,
  output logic        DF_out,
  output logic        flag_stall,
  output logic        pend_err
);
  logic [5:0] flg_q, flg_d, src, pop6;
  logic df_q, df_d, perr_q, perr_d;
  logic [6:0][PEND_W-1:0] cnt_q, cnt_d;
  logic [6:0] wm, im, nz, full, rd, ld;
  logic unused_popf;
  assign unused_popf = ^{wb_popf_data[31:12], wb_popf_data[9:8], wb_popf_data[5],
                         wb_popf_data[3], wb_popf_data[1]};
  assign src  = wb_cmps_sel ? wb_cmps_flags : wb_flags;
  assign pop6 = {wb_popf_data[11], wb_popf_data[7], wb_popf_data[6],
                 wb_popf_data[4], wb_popf_data[2], wb_popf_data[0]};
  assign ld = {iss_ld_df, iss_ld_flags};
  assign rd = {iss_rd_df, iss_rd_flags};
  assign wm = wb_valid ? (wb_popf ? 7'h7F : {wb_ld_df, wb_ld_flags}) : 7'h00;
  assign flag_stall = iss_valid & (|(rd & nz) | |(ld & full));
  assign im = ld & {7{iss_valid & ~flag_stall & ~flush}};
  always_comb begin
    nz = '0;
    full = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < 7; i++) begin
      nz[i] = cnt_q[i] != '0;
      full[i] = &cnt_q[i];
      cnt_d[i] = flush ? '0 :
                 (im[i] & ~wm[i]) ? cnt_q[i] + PEND_W'(1) :
                 (wm[i] & ~im[i] & nz[i]) ? cnt_q[i] - PEND_W'(1) : cnt_q[i];
    end
    flg_d = !wb_valid ? flg_q : wb_popf ? pop6 : (wb_ld_flags & src) | (~wb_ld_flags & flg_q);
    df_d = !wb_valid ? df_q : wb_popf ? wb_popf_data[10] : wb_ld_df ? wb_df_val : df_q;
    // a writeback older than a flush still commits but cannot flag an underflow
    perr_d = perr_q | (~flush & |(wm & ~nz));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flg_q <= '0;
      df_q <= 1'b0;
      perr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      flg_q <= flg_d;
      df_q <= df_d;
      perr_q <= perr_d;
      cnt_q <= cnt_d;
    end
  end
  assign eflags = {20'd0, flg_q[5], df_q, 2'b00, flg_q[4], flg_q[3], 1'b0,
                   flg_q[2], 1'b0, flg_q[1], 1'b1, flg_q[0]};
  assign CF_out = flg_q[0];
  assign AF_out = flg_q[2];
  assign DF_out = df_q;
  assign pend_err = perr_q;
endmodule

// File: tb/tb_eflags_wb.sv
// tb_eflags_wb: directed per-cycle vectors for the EFLAGS register and flag scoreboard
module tb_eflags_wb;
  logic clk = 1'b0;
  logic rst, wb_valid, wb_cmps_sel, wb_ld_df, wb_df_val, wb_popf;
  logic [5:0] wb_ld_flags, wb_flags, wb_cmps_flags, iss_ld_flags, iss_rd_flags;
  logic [31:0] wb_popf_data, eflags;
  logic iss_valid, iss_ld_df, iss_rd_df, flush;
  logic CF_out, AF_out, DF_out, flag_stall, pend_err;
  int checks = 0;
  int errors = 0;

  eflags_wb #(.PEND_W(2)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ld_flags(wb_ld_flags),
    .wb_flags(wb_flags), .wb_cmps_sel(wb_cmps_sel), .wb_cmps_flags(wb_cmps_flags),
    .wb_ld_df(wb_ld_df), .wb_df_val(wb_df_val), .wb_popf(wb_popf),
    .wb_popf_data(wb_popf_data), .iss_valid(iss_valid), .iss_ld_flags(iss_ld_flags),
    .iss_ld_df(iss_ld_df), .iss_rd_flags(iss_rd_flags), .iss_rd_df(iss_rd_df),
    .flush(flush), .eflags(eflags), .CF_out(CF_out), .AF_out(AF_out),
    .DF_out(DF_out), .flag_stall(flag_stall), .pend_err(pend_err)
  );

  always #5 clk = ~clk;

  // wld/ild/ird are {DF, OF, SF, ZF, AF, PF, CF}; stall is expected before the edge,
  // efl/perr after it
  typedef struct {
    logic rst, wbv;
    logic [6:0] wld;
    logic [5:0] wfl;
    logic csel;
    logic [5:0] cfl;
    logic dfv, popf;
    logic [31:0] pdata;
    logic iv;
    logic [6:0] ild, ird;
    logic flush, stall;
    logic [31:0] efl;
    logic perr;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; wb_valid = v.wbv; wb_ld_df = v.wld[6]; wb_ld_flags = v.wld[5:0];
    wb_flags = v.wfl; wb_cmps_sel = v.csel; wb_cmps_flags = v.cfl; wb_df_val = v.dfv;
    wb_popf = v.popf; wb_popf_data = v.pdata; iss_valid = v.iv;
    iss_ld_df = v.ild[6]; iss_ld_flags = v.ild[5:0];
    iss_rd_df = v.ird[6]; iss_rd_flags = v.ird[5:0]; flush = v.flush;
  endtask

  initial begin
    vec_t idle;
    idle = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    drive(idle);
    // reset with a pending full writeback: nothing commits
    tv.push_back(vec_t'{1,1,7'h3F,6'h3F,0,0,0,0,0,0,0,0,0, 0,32'h2,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,32'h2,0});
    // RAW on CF
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h01,0,0, 0,32'h2,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,0,7'h01,0, 1,32'h2,0});
    tv.push_back(vec_t'{0,1,7'h01,6'h01,0,0,0,0,0,1,0,7'h01,0, 1,32'h3,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,0,7'h01,0, 0,32'h3,0});
    // partial load keeps CF
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h3F,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h3E,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,1,7'h3F,6'h3F,0,0,0,0,0,0,0,0,0, 0,32'h8D7,0});
    tv.push_back(vec_t'{0,1,7'h3E,6'h00,0,0,0,0,0,0,0,0,0, 0,32'h3,0});
    // ZF counter saturation
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h08,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h08,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h08,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h08,0,0, 1,32'h3,0});
    tv.push_back(vec_t'{0,1,7'h08,6'h08,0,0,0,0,0,1,7'h08,0,0, 1,32'h43,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h08,0,0, 0,32'h43,0});
    tv.push_back(vec_t'{0,1,7'h08,6'h00,0,0,0,0,0,0,0,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,1,7'h08,6'h00,0,0,0,0,0,0,0,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,1,7'h08,6'h00,0,0,0,0,0,0,0,0,0, 0,32'h3,0});
    // CMPS select, then POPF image with DF and OF
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h3F,0,0, 0,32'h3,0});
    tv.push_back(vec_t'{0,1,7'h3F,6'h3F,1,6'h08,0,0,0,0,0,0,0, 0,32'h42,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h7F,0,0, 0,32'h42,0});
    tv.push_back(vec_t'{0,1,7'h00,6'h3F,0,0,0,1,32'h0C01,0,0,0,0, 0,32'hC03,0});
    // DF RAW
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h40,0,0, 0,32'hC03,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,0,7'h40,0, 1,32'hC03,0});
    tv.push_back(vec_t'{0,1,7'h40,0,0,0,0,0,0,1,0,7'h40,0, 1,32'h803,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,0,7'h40,0, 0,32'h803,0});
    // flush with older SF commit, flush hides underflow, then real underflow
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h10,0,0, 0,32'h803,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7'h10,0,0, 0,32'h803,0});
    tv.push_back(vec_t'{0,1,7'h10,6'h10,0,0,0,0,0,1,7'h10,0,1, 0,32'h883,0});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,0,7'h10,0, 0,32'h883,0});
    tv.push_back(vec_t'{0,1,7'h01,6'h00,0,0,0,0,0,0,0,0,1, 0,32'h882,0});
    tv.push_back(vec_t'{0,1,7'h10,6'h00,0,0,0,0,0,0,0,0,0, 0,32'h802,1});
    tv.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,32'h802,1});
    tv.push_back(vec_t'{1,1,7'h3F,6'h3F,0,0,0,0,0,0,0,0,0, 0,32'h2,0});
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #1 chk($sformatf("stall[%0d]", i), 32'(flag_stall), 32'(tv[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("eflags[%0d]", i), eflags, tv[i].efl);
      chk($sformatf("pend_err[%0d]", i), 32'(pend_err), 32'(tv[i].perr));
      chk($sformatf("CF_out[%0d]", i), 32'(CF_out), 32'(tv[i].efl[0]));
      chk($sformatf("AF_out[%0d]", i), 32'(AF_out), 32'(tv[i].efl[4]));
      chk($sformatf("DF_out[%0d]", i), 32'(DF_out), 32'(tv[i].efl[10]));
    end
    // flush releases a stalled reader on the following cycle
    @(negedge clk);
    drive(idle);
    iss_valid = 1'b1; iss_ld_flags = 6'h01;
    #1 chk("seq_wr_stall", 32'(flag_stall), 32'd0);
    @(negedge clk);
    iss_ld_flags = 6'h00; iss_rd_flags = 6'h01;
    #1 chk("seq_rd_stall", 32'(flag_stall), 32'd1);
    flush = 1'b1;
    #1 chk("seq_flush_stall", 32'(flag_stall), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("seq_post_flush", 32'(flag_stall), 32'd0);
    @(negedge clk);
    drive(idle);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
